// File: rtl/sram_dp_clr_if.sv
// Port bundle for sram_dp_clr: clear control, write port and read port.
interface sram_dp_clr_if #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 32
);
  logic                      clear_req;
  logic                      busy;
  logic                      wr_en;
  logic [ADDR_SIZE-1:0]      wr_addr;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      rd_en;
  logic [ADDR_SIZE-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;

  modport master (
    output clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/sram_dp_clr.sv
// Simple-dual-port SRAM with byte enables, 1/2-cycle read latency and a clear sweep engine.
// Define SRAM_BYPASS_EN for write-first forwarding on same-address read/write; default is read-first.
module sram_dp_clr #(
  parameter int                     ADDR_SIZE    = 8,
  parameter int                     DATA_WIDTH   = 32,
  parameter int                     READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE  = '0
) (
  input  logic            clk,
  input  logic            rst,
  sram_dp_clr_if.slave    bus
);
  localparam int RAM_DEPTH = 1 << ADDR_SIZE;
  localparam int NB        = DATA_WIDTH / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_SIZE-1:0]    clr_addr_q, clr_addr_d;
  logic                    s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0]   s1_dat_q, s1_dat_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    wr_acc, rd_acc;
  logic                    mem_we;
  logic [ADDR_SIZE-1:0]    mem_waddr;
  logic [NB-1:0]           mem_wbe;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign wr_acc = (state_q == IDLE) && bus.wr_en;
  assign rd_acc = (state_q == IDLE) && bus.rd_en;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDR_SIZE{1'b1}}) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end
      end
      default: begin
        if (bus.clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  // The sweep owns the write port; user writes only land while idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wbe   = bus.wr_be;
    mem_wdata = bus.wr_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wbe   = '1;
      mem_wdata = CLEAR_VALUE;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we && mem_wbe[i]) begin
        mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[bus.rd_addr];
`ifdef SRAM_BYPASS_EN
    if (wr_acc && (bus.wr_addr == bus.rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) begin
          rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
        end
      end
    end
`endif
  end

  // LAT=2 adds one register between the array sample and the output stage.
  always_comb begin
    s1_vld_d   = rd_acc;
    s1_dat_d   = rd_acc ? rd_word : s1_dat_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (READ_LATENCY == 1) begin
      rd_valid_d = rd_acc;
      if (rd_acc) begin
        rd_data_d = rd_word;
      end
    end else begin
      rd_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        rd_data_d = s1_dat_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_dat_q   <= s1_dat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.busy     = (state_q == CLEAR);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
endmodule
